// File: rtl/dvi_cfg_ctrl_pkg.sv
// dvi_cfg_ctrl shared definitions
// States, register table constants and widths
package dvi_cfg_ctrl_pkg;

  typedef enum logic [2:0] {
    PWRUP,
    ISSUE,
    WAIT_XFER,
    GAP,
    READY
  } state_t;

  localparam int TABLE_LEN = 5;
  localparam int IDX_W     = 3;
  localparam int TMR_W     = 24;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TABLE_LEN - 1);

  localparam logic [7:0] ADDR_0 = 8'h49;
  localparam logic [7:0] ADDR_1 = 8'h21;
  localparam logic [7:0] ADDR_2 = 8'h33;
  localparam logic [7:0] ADDR_3 = 8'h34;
  localparam logic [7:0] ADDR_4 = 8'h36;

  localparam logic [7:0] DATA_0   = 8'hC0;
  localparam logic [7:0] DATA_1   = 8'h09;
  localparam logic [7:0] DATA_2_A = 8'h06;
  localparam logic [7:0] DATA_2_B = 8'h08;
  localparam logic [7:0] DATA_3_A = 8'h26;
  localparam logic [7:0] DATA_3_B = 8'h16;
  localparam logic [7:0] DATA_4_A = 8'hA0;
  localparam logic [7:0] DATA_4_B = 8'h60;

endpackage

// File: rtl/dvi_cfg_rom.sv
// dvi_cfg_rom: register table lookup
// Maps table index and mode to an address/data pair
module dvi_cfg_rom
  import dvi_cfg_ctrl_pkg::*;
(
  input  logic [IDX_W-1:0] idx,
  input  logic             mode,
  output logic [7:0]       addr,
  output logic [7:0]       data
);

  // pure combinational table, mode 1 selects the B column
  always_comb begin
    addr = 8'h00;
    data = 8'h00;
    case (idx)
      3'd0: begin
        addr = ADDR_0;
        data = DATA_0;
      end
      3'd1: begin
        addr = ADDR_1;
        data = DATA_1;
      end
      3'd2: begin
        addr = ADDR_2;
        data = mode ? DATA_2_B : DATA_2_A;
      end
      3'd3: begin
        addr = ADDR_3;
        data = mode ? DATA_3_B : DATA_3_A;
      end
      3'd4: begin
        addr = ADDR_4;
        data = mode ? DATA_4_B : DATA_4_A;
      end
      default: begin
        addr = 8'h00;
        data = 8'h00;
      end
    endcase
  end

endmodule

// File: rtl/dvi_cfg_ctrl.sv
// dvi_cfg_ctrl: DVI transmitter configuration sequencer
// Pushes the register table through the I2C write engine
module dvi_cfg_ctrl
  import dvi_cfg_ctrl_pkg::*;
#(
  parameter int   CLK_RATE_MHZ   = 25,
  parameter int   POWERUP_CYCLES = CLK_RATE_MHZ * 1000,
  parameter int   GAP_CYCLES     = CLK_RATE_MHZ * 30,
  parameter int   TIMEOUT_CYCLES = CLK_RATE_MHZ * 4000,
  parameter logic DEFAULT_MODE   = 1'b1
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       mode_sel,
  input  logic       mode_req,
  output logic       wr_req,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  input  logic       wr_busy,
  input  logic       wr_done,
  output logic       Done,
  output logic       busy,
  output logic       cfg_mode,
  output logic       err
);

  localparam logic [TMR_W-1:0] PWR_TC = TMR_W'(POWERUP_CYCLES - 1);
  localparam logic [TMR_W-1:0] GAP_TC = TMR_W'(GAP_CYCLES - 1);
  localparam logic [TMR_W-1:0] TMO_TC = TMR_W'(TIMEOUT_CYCLES - 1);

  state_t           state;
  state_t           state_n;
  logic [TMR_W-1:0] tmr;
  logic             tmr_clr;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] idx_n;
  logic             seq_mode;
  logic             seq_n;
  logic             pend;
  logic             pend_n;
  logic             pend_mode;
  logic             pmode_n;
  logic             cfg_n;
  logic             err_n;
  logic [7:0]       rom_addr;
  logic [7:0]       rom_data;

  dvi_cfg_rom u_rom (
    .idx  (idx),
    .mode (seq_mode),
    .addr (rom_addr),
    .data (rom_data)
  );

  // next state, table index, pending request and sticky error
  always_comb begin
    state_n = state;
    idx_n   = idx;
    seq_n   = seq_mode;
    pend_n  = pend;
    pmode_n = pend_mode;
    cfg_n   = cfg_mode;
    err_n   = err;
    if (mode_req && state != READY) begin
      pend_n  = 1'b1;
      pmode_n = mode_sel;
    end
    unique case (state)
      PWRUP: begin
        if (tmr == PWR_TC) begin
          state_n = ISSUE;
          idx_n   = '0;
          seq_n   = DEFAULT_MODE;
        end
      end
      ISSUE: begin
        if (wr_busy) begin
          state_n = WAIT_XFER;
        end else if (tmr == TMO_TC) begin
          err_n   = 1'b1;
          state_n = GAP;
        end
      end
      WAIT_XFER: begin
        if (wr_done) begin
          state_n = GAP;
        end else if (tmr == TMO_TC) begin
          err_n   = 1'b1;
          state_n = GAP;
        end
      end
      GAP: begin
        if (tmr == GAP_TC) begin
          if (idx == LAST_IDX) begin
            cfg_n = seq_mode;
            if (pend_n) begin
              state_n = ISSUE;
              idx_n   = '0;
              seq_n   = pmode_n;
              pend_n  = 1'b0;
            end else begin
              state_n = READY;
            end
          end else begin
            state_n = ISSUE;
            idx_n   = idx + 1'b1;
          end
        end
      end
      READY: begin
        if (mode_req) begin
          state_n = ISSUE;
          idx_n   = '0;
          seq_n   = mode_sel;
        end
      end
      default: state_n = PWRUP;
    endcase
  end

  // timer restarts on each state change, but keeps running ISSUE->WAIT_XFER
  always_comb begin
    tmr_clr = 1'b0;
    if (state_n != state) begin
      tmr_clr = !(state == ISSUE && state_n == WAIT_XFER);
    end
  end

  // state, timer and sequence bookkeeping registers
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state     <= PWRUP;
      tmr       <= '0;
      idx       <= '0;
      seq_mode  <= DEFAULT_MODE;
      pend      <= 1'b0;
      pend_mode <= 1'b0;
    end else begin
      state     <= state_n;
      idx       <= idx_n;
      seq_mode  <= seq_n;
      pend      <= pend_n;
      pend_mode <= pmode_n;
      if (tmr_clr || state == READY) begin
        tmr <= '0;
      end else begin
        tmr <= tmr + 1'b1;
      end
    end
  end

  // registered outputs toward the engine and the mode logic
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      wr_req   <= 1'b0;
      wr_addr  <= 8'h00;
      wr_data  <= 8'h00;
      Done     <= 1'b0;
      busy     <= 1'b1;
      cfg_mode <= DEFAULT_MODE;
      err      <= 1'b0;
    end else begin
      wr_req <= (state == ISSUE) && (state_n == ISSUE);
      if (state == ISSUE) begin
        wr_addr <= rom_addr;
        wr_data <= rom_data;
      end
      Done     <= (state_n == READY);
      busy     <= (state_n != READY);
      cfg_mode <= cfg_n;
      err      <= err_n;
    end
  end

endmodule

// File: tb/tb_dvi_cfg_ctrl.sv
// tb_dvi_cfg_ctrl: bench for the DVI configuration sequencer
// Engine model, expected-write queue and per-cycle compare
module tb_dvi_cfg_ctrl;

  localparam int P     = 200;
  localparam int G     = 20;
  localparam int T     = 300;
  localparam int FRAME = 28;
  localparam int LIM   = 3000;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       mode_sel = 1'b0;
  logic       mode_req = 1'b0;
  logic       wr_busy = 1'b0;
  logic       wr_done = 1'b0;
  logic       wr_req;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       Done;
  logic       busy;
  logic       cfg_mode;
  logic       err;

  dvi_cfg_ctrl #(
    .POWERUP_CYCLES (P),
    .GAP_CYCLES     (G),
    .TIMEOUT_CYCLES (T),
    .DEFAULT_MODE   (1'b1)
  ) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .mode_sel (mode_sel),
    .mode_req (mode_req),
    .wr_req   (wr_req),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .wr_busy  (wr_busy),
    .wr_done  (wr_done),
    .Done     (Done),
    .busy     (busy),
    .cfg_mode (cfg_mode),
    .err      (err)
  );

  initial forever #5 Clk = ~Clk;

  int npass = 0;
  int ntot  = 0;
  int cyc   = 0;

  always @(posedge Clk) cyc <= cyc + 1;

  logic [15:0] tab_a [5] = '{16'h49C0, 16'h2109, 16'h3306, 16'h3426, 16'h36A0};
  logic [15:0] tab_b [5] = '{16'h49C0, 16'h2109, 16'h3308, 16'h3416, 16'h3660};

  logic [15:0] exp_q [$];
  int   nrise = 0;
  int   last_rise_cyc = 0;
  int   done_rises = 0;
  int   drop_at = 0;
  int   busy_dly = 1;
  int   err_due = -1;
  int   gap_start = 0;
  bit   gap_valid = 0;
  bit   err_m = 0;
  bit   cfg_m = 1;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    ntot++;
    if (got === want) npass++;
    else $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, got, want, cyc);
  endtask

  task automatic push_seq(input bit m);
    for (int i = 0; i < 5; i++) exp_q.push_back(m ? tab_b[i] : tab_a[i]);
  endtask

  task automatic pulse(input bit m);
    mode_sel = m;
    mode_req = 1'b1;
    @(negedge Clk);
    mode_req = 1'b0;
  endtask

  task automatic wait_rise(input string nm, input int n);
    int k = 0;
    while (nrise < n && k < LIM) begin
      @(negedge Clk);
      k++;
    end
    chk(nm, 32'(nrise >= n), 32'd1);
  endtask

  task automatic wait_done(input string nm);
    int k = 0;
    while (!Done && k < LIM) begin
      @(negedge Clk);
      k++;
    end
    chk(nm, 32'(Done), 32'd1);
  endtask

  // engine: accepts after busy_dly cycles of wr_req, 28-cycle frame
  initial begin
    int st = 0;
    int cnt = 0;
    forever begin
      @(posedge Clk);
      #1;
      wr_done = 1'b0;
      if (Reset) begin
        wr_busy = 1'b0;
        st = 0;
        cnt = 0;
      end else if (st == 0) begin
        if (wr_req) begin
          cnt++;
          if (cnt >= busy_dly) begin
            wr_busy = 1'b1;
            st = 1;
            cnt = 0;
          end
        end else begin
          cnt = 0;
        end
      end else begin
        cnt++;
        if (cnt == FRAME) begin
          wr_busy = 1'b0;
          if (nrise != drop_at) wr_done = 1'b1;
          st = 0;
          cnt = 0;
        end
      end
    end
  end

  // per-cycle compare against the transaction-level model
  initial begin
    logic        prev_req = 1'b0;
    logic        prev_done = 1'b0;
    logic [15:0] prev_ad = 16'h0;
    int          run = 0;
    forever begin
      @(negedge Clk);
      if (Reset) begin
        prev_req = 1'b0;
        prev_done = 1'b0;
        prev_ad = 16'h0;
        run = 0;
        nrise = 0;
        err_m = 0;
        err_due = -1;
        gap_valid = 0;
      end else begin
        if (err_due == cyc) begin
          err_m = 1;
          gap_start = cyc;
          gap_valid = 1;
        end
        chk("busy_vs_done", 32'(busy), 32'(!Done));
        chk("err", 32'(err), 32'(err_m));
        if (wr_req && !prev_req) begin
          nrise++;
          last_rise_cyc = cyc;
          if (exp_q.size() == 0) begin
            ntot++;
            $display("FAIL extra_write: got %h want none", {wr_addr, wr_data});
          end else begin
            chk("write", 32'({wr_addr, wr_data}), 32'(exp_q.pop_front()));
          end
          if (gap_valid) chk("gap_to_req", cyc, gap_start + G + 1);
          gap_valid = 0;
          if (nrise == drop_at) err_due = cyc + T - 1;
          run = 0;
        end else begin
          chk("addr_stable", 32'({wr_addr, wr_data}), 32'(prev_ad));
        end
        if (wr_req) run++;
        if (!wr_req && prev_req) chk("req_len", run, busy_dly);
        if (wr_done) begin
          gap_start = cyc + 1;
          gap_valid = 1;
        end
        if (Done && !prev_done) begin
          done_rises++;
          chk("queue_empty_at_done", exp_q.size(), 0);
          chk("cfg_at_done", 32'(cfg_mode), 32'(cfg_m));
          if (gap_valid) chk("gap_to_done", cyc, gap_start + G);
          gap_valid = 0;
        end
        prev_req = wr_req;
        prev_done = Done;
        prev_ad = {wr_addr, wr_data};
      end
    end
  end

  // directed scenarios
  initial begin
    int c;
    int base;
    int dr;
    cfg_m = 1;
    repeat (3) @(negedge Clk);
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_done", 32'(Done), 32'd0);
    chk("rst_cfg", 32'(cfg_mode), 32'd1);
    push_seq(1);
    Reset = 1'b0;
    c = cyc;
    wait_rise("boot_first_write", 1);
    chk("pwrup_delay", last_rise_cyc, c + P + 1);
    wait_done("boot_done");
    chk("boot_cfg", 32'(cfg_mode), 32'd1);
    chk("boot_err", 32'(err), 32'd0);

    // mode A request from READY
    @(negedge Clk);
    push_seq(0);
    cfg_m = 0;
    c = cyc;
    base = nrise;
    pulse(0);
    chk("done_fall", 32'(Done), 32'd0);
    wait_rise("a_first_write", base + 1);
    chk("a_no_pwrup", last_rise_cyc, c + 2);
    wait_done("a_done");
    chk("a_cfg", 32'(cfg_mode), 32'd0);

    // B replay with A then B requested mid-sequence
    @(negedge Clk);
    push_seq(1);
    push_seq(1);
    cfg_m = 1;
    dr = done_rises;
    base = nrise;
    pulse(1);
    wait_rise("mid_w2", base + 2);
    pulse(0);
    wait_rise("mid_w4", base + 4);
    pulse(1);
    wait_done("mid_done");
    chk("mid_single_done", done_rises - dr, 1);
    chk("mid_cfg", 32'(cfg_mode), 32'd1);

    // engine drops wr_done on write 3
    @(negedge Clk);
    push_seq(0);
    cfg_m = 0;
    base = nrise;
    drop_at = base + 3;
    pulse(0);
    wait_done("tmo_done");
    chk("tmo_err", 32'(err), 32'd1);
    chk("tmo_cfg", 32'(cfg_mode), 32'd0);
    repeat (20) @(negedge Clk);
    chk("tmo_err_sticky", 32'(err), 32'd1);
    drop_at = 0;

    // slow acceptance by the engine
    busy_dly = 10;
    @(negedge Clk);
    push_seq(0);
    cfg_m = 0;
    pulse(0);
    wait_done("slow_done");
    chk("slow_cfg", 32'(cfg_mode), 32'd0);

    // asynchronous reset during write 3
    @(negedge Clk);
    push_seq(1);
    base = nrise;
    pulse(1);
    wait_rise("rst_w3", base + 3);
    repeat (2) @(negedge Clk);
    #2 Reset = 1'b1;
    #1;
    chk("arst_wr_req", 32'(wr_req), 32'd0);
    chk("arst_addr", 32'(wr_addr), 32'd0);
    chk("arst_data", 32'(wr_data), 32'd0);
    chk("arst_done", 32'(Done), 32'd0);
    chk("arst_busy", 32'(busy), 32'd1);
    chk("arst_cfg", 32'(cfg_mode), 32'd1);
    chk("arst_err", 32'(err), 32'd0);
    exp_q.delete();
    push_seq(1);
    cfg_m = 1;
    busy_dly = 1;
    repeat (3) @(negedge Clk);
    Reset = 1'b0;
    c = cyc;
    wait_rise("reboot_first_write", 1);
    chk("reboot_pwrup", last_rise_cyc, c + P + 1);
    wait_done("reboot_done");
    chk("reboot_cfg", 32'(cfg_mode), 32'd1);
    chk("reboot_err", 32'(err), 32'd0);

    repeat (5) @(negedge Clk);
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
